sm83_mem_responder: RTL and testbench
=====================================

Name: sm83_mem_responder

Overview:
- Bus responder serving the SM83 core's memory requests: the target-side counterpart of the control unit's address-select, memory-read and memory-write strobes.
- Owns work RAM, high RAM (0xFF80–0xFFFE) and the IE register (0xFFFF).
- Accepts one request at a time over a valid/ready handshake, with programmable wait states.
- Returns a one-cycle response pulse carrying read data or a decode error.

Parameters:
- WRAM_BASE, 16'hC000, first address of work RAM; must be aligned to WRAM_DEPTH.
- WRAM_DEPTH, 8192, work-RAM bytes; power of two, 256..8192.
- WAIT_CYCLES, 0, extra stall cycles inserted between accept and response; range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  16  byte address.
- req_wdata  in  8  write data.
- req_ready  out  1  responder can accept a request this cycle.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  8  read data; held between responses.
- rsp_err  out  1  access hit an unmapped address; qualified by rsp_valid.

Behaviour:
- Reset (async assert, sync deassert internally not required):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=8'hFF, rsp_err=0, IE=8'h00, wait counter=0.
  - RAM arrays are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready, capture addr/we/wdata into holding registers. Go to WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES), else RESP.
  - WAIT: req_ready=0. Counter decrements each cycle; go to RESP in the cycle the counter reads 1.
  - RESP: req_ready=0, rsp_valid=1 for exactly this cycle. Unconditionally return to IDLE next cycle.
- Latency:
  - Accept at cycle N; rsp_valid at N+1+WAIT_CYCLES.
  - Maximum throughput is one request per 2+WAIT_CYCLES cycles.
- Request inputs are ignored outside the IDLE accept cycle. Changes to req_* after acceptance have no effect.
- Address decode (on captured address):
  - WRAM: WRAM_BASE <= addr < WRAM_BASE+WRAM_DEPTH; index = addr[log2(WRAM_DEPTH)-1:0].
  - HRAM: 0xFF80..0xFFFE; index = addr[6:0]-0, 127 entries.
  - IE: 0xFFFF.
  - Everything else is unmapped.
- Writes:
  - Committed on the RESP cycle's clock edge only, exactly once per request.
  - rsp_rdata is unchanged on a write response.
- Reads:
  - rsp_rdata is registered during RESP and reflects storage contents as of the RESP cycle.
  - rsp_rdata holds its value until the next read response.
- Unmapped access:
  - Read returns 8'hFF.
  - Write is discarded.
  - rsp_err=1 during RESP; rsp_err=0 on every other response.
- Read of IE returns all 8 bits as written. No masking.
- A read immediately after a write to the same address returns the newly written value, since the write is committed before the next accept.
- Reset asserted in WAIT or RESP aborts the request:
  - No write commits unless its RESP edge already occurred.
  - Outputs return to reset values immediately.
- Address 0xFF7F and WRAM_BASE+WRAM_DEPTH are unmapped, covering the boundaries on both sides.

Test Plan:
- Reset, then write 8'hA5 to 0xC000 and read back with WAIT_CYCLES=0:
  - Write: req_ready drops the cycle after accept; rsp_valid on cycle N+1, rsp_err=0.
  - Read: rsp_rdata=8'hA5 at N+1.
- HRAM/IE boundaries:
  - Write 8'h11→0xFF80, 8'h22→0xFFFE, 8'h1F→0xFFFF; read each back → 8'h11, 8'h22, 8'h1F.
  - Read 0xFF7F → rsp_rdata=8'hFF, rsp_err=1.
- Unmapped write: write 8'h55→0x8000, then read 0x8000 → rsp_rdata=8'hFF, rsp_err=1 on both responses, no storage changed.
- WAIT_CYCLES=3: accept at cycle 10 → rsp_valid only at cycle 14; req_ready low cycles 11–14, high at 15. Toggling req_addr and req_wdata during the wait has no effect.
- Reset mid-WAIT (WAIT_CYCLES=3):
  - Write 8'h77 to 0xC010, assert rst_n=0 one cycle after accept.
  - No rsp_valid is produced; a later read of 0xC010 returns its prior value; IE reads 8'h00.
- Back-to-back requests: req_valid held high with 4 reads → accepts spaced exactly 2 cycles apart (WAIT_CYCLES=0), 4 rsp_valid pulses, rsp_rdata stable between pulses.

Source files
------------

// File: rtl/sm83_mem_responder.sv
// Target-side responder for SM83 memory requests: work RAM, high RAM and the IE register
// behind a valid/ready request port with optional wait states and a one-cycle response strobe.
module sm83_mem_responder #(
    parameter logic [15:0] WRAM_BASE   = 16'hC000,
    parameter int unsigned WRAM_DEPTH  = 8192,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(WRAM_DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;
    typedef enum logic [1:0] {RegNone, RegWram, RegHram, RegIe} region_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q;
    logic        we_q;
    logic [7:0]  wdata_q;
    logic [7:0]  ie_q;
    logic [7:0]  rdata_q;
    logic        accept;

    logic [7:0]  wram [WRAM_DEPTH];
    logic [7:0]  hram [127];

    // WRAM_BASE is aligned to WRAM_DEPTH, so a hit is a compare of the upper address bits.
    function automatic region_e decode(input logic [15:0] a);
        if (a == 16'hFFFF) begin
            return RegIe;
        end else if (a >= 16'hFF80) begin
            return RegHram;
        end else if (a[15:AW] == WRAM_BASE[15:AW]) begin
            return RegWram;
        end else begin
            return RegNone;
        end
    endfunction

    // Read lookup uses the live request when responding straight out of IDLE.
    logic [15:0] lk_addr;
    logic        lk_we;
    region_e     lk_region;
    region_e     held_region;
    logic [7:0]  lk_data;
    logic        load_rdata;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                rsp_valid = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        lk_addr     = (state_q == StIdle) ? req_addr : addr_q;
        lk_we       = (state_q == StIdle) ? req_we : we_q;
        lk_region   = decode(lk_addr);
        held_region = decode(addr_q);
        load_rdata  = (state_d == StResp) && (state_q != StResp) && !lk_we;
        unique case (lk_region)
            RegWram: lk_data = wram[lk_addr[AW-1:0]];
            RegHram: lk_data = hram[lk_addr[6:0]];
            RegIe:   lk_data = ie_q;
            default: lk_data = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= 16'h0000;
            we_q    <= 1'b0;
            wdata_q <= 8'h00;
            ie_q    <= 8'h00;
            rdata_q <= 8'hFF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= req_addr;
                we_q    <= req_we;
                wdata_q <= req_wdata;
            end
            if (load_rdata) begin
                rdata_q <= lk_data;
            end
            if (state_q == StResp && we_q && held_region == RegIe) begin
                ie_q <= wdata_q;
            end
        end
    end

    // Arrays carry no reset; an aborted request never reaches StResp so nothing commits.
    always_ff @(posedge clk) begin
        if (state_q == StResp && we_q) begin
            if (held_region == RegWram) begin
                wram[addr_q[AW-1:0]] <= wdata_q;
            end
            if (held_region == RegHram) begin
                hram[addr_q[6:0]] <= wdata_q;
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = (state_q == StResp) && (held_region == RegNone);

endmodule

// File: tb/tb_sm83_mem_responder.sv
// Directed bench: one responder with no wait states, one with three, driven from vector tables
// and hand-timed sequences.
module tb_sm83_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0_n, v0, we0;
    logic [15:0] a0;
    logic [7:0]  wd0;
    logic        rdy0, rv0, err0;
    logic [7:0]  rd0;

    logic        rst3_n, v3, we3;
    logic [15:0] a3;
    logic [7:0]  wd3;
    logic        rdy3, rv3, err3;
    logic [7:0]  rd3;

    sm83_mem_responder #(.WRAM_BASE(16'hC000), .WRAM_DEPTH(8192), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .req_valid(v0), .req_we(we0), .req_addr(a0),
        .req_wdata(wd0), .req_ready(rdy0), .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(err0)
    );

    sm83_mem_responder #(.WRAM_BASE(16'hC000), .WRAM_DEPTH(8192), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .req_valid(v3), .req_we(we3), .req_addr(a3),
        .req_wdata(wd3), .req_ready(rdy3), .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(err3)
    );

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        logic        err;
    } vec_t;

    vec_t tbl[16];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Zero-wait request: accept in the first cycle, response strictly in the next.
    task automatic req0(input vec_t v, input string nm);
        @(negedge clk);
        check({nm, " ready"}, 16'(rdy0), 16'd1);
        check({nm, " idle rsp_valid"}, 16'(rv0), 16'd0);
        v0 = 1'b1; we0 = v.we; a0 = v.addr; wd0 = v.wdata;
        @(negedge clk);
        v0 = 1'b0;
        check({nm, " rsp_valid"}, 16'(rv0), 16'd1);
        check({nm, " ready low"}, 16'(rdy0), 16'd0);
        check({nm, " rdata"}, 16'(rd0), 16'(v.rdata));
        check({nm, " err"}, 16'(err0), 16'(v.err));
    endtask

    task automatic req3(input vec_t v, input string nm);
        bit got;
        @(negedge clk);
        v3 = 1'b1; we3 = v.we; a3 = v.addr; wd3 = v.wdata;
        @(negedge clk);
        v3 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (rv3) got = 1'b1;
            else @(negedge clk);
        end
        check({nm, " response seen"}, 16'(got), 16'd1);
        if (got) begin
            check({nm, " rdata"}, 16'(rd3), 16'(v.rdata));
            check({nm, " err"}, 16'(err3), 16'(v.err));
        end
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] b2b_addr[4];
        logic [7:0]  b2b_data[4];

        tbl[0]  = '{1'b1, 16'hC000, 8'hA5, 8'hFF, 1'b0};
        tbl[1]  = '{1'b0, 16'hC000, 8'h00, 8'hA5, 1'b0};
        tbl[2]  = '{1'b1, 16'hFF80, 8'h11, 8'hA5, 1'b0};
        tbl[3]  = '{1'b1, 16'hFFFE, 8'h22, 8'hA5, 1'b0};
        tbl[4]  = '{1'b1, 16'hFFFF, 8'h1F, 8'hA5, 1'b0};
        tbl[5]  = '{1'b0, 16'hFF80, 8'h00, 8'h11, 1'b0};
        tbl[6]  = '{1'b0, 16'hFFFE, 8'h00, 8'h22, 1'b0};
        tbl[7]  = '{1'b0, 16'hFFFF, 8'h00, 8'h1F, 1'b0};
        tbl[8]  = '{1'b0, 16'hFF7F, 8'h00, 8'hFF, 1'b1};
        tbl[9]  = '{1'b1, 16'h8000, 8'h55, 8'hFF, 1'b1};
        tbl[10] = '{1'b0, 16'h8000, 8'h00, 8'hFF, 1'b1};
        tbl[11] = '{1'b0, 16'hE000, 8'h00, 8'hFF, 1'b1};
        tbl[12] = '{1'b1, 16'hDFFF, 8'h3C, 8'hFF, 1'b0};
        tbl[13] = '{1'b0, 16'hDFFF, 8'h00, 8'h3C, 1'b0};
        tbl[14] = '{1'b0, 16'hC000, 8'h00, 8'hA5, 1'b0};
        tbl[15] = '{1'b0, 16'hFFFF, 8'h00, 8'h1F, 1'b0};

        rst0_n = 1'b0; rst3_n = 1'b0;
        v0 = 1'b0; we0 = 1'b0; a0 = 16'h0; wd0 = 8'h0;
        v3 = 1'b0; we3 = 1'b0; a3 = 16'h0; wd3 = 8'h0;
        repeat (2) @(negedge clk);
        check("reset ready", 16'(rdy0), 16'd1);
        check("reset rsp_valid", 16'(rv0), 16'd0);
        check("reset rdata", 16'(rd0), 16'h00FF);
        check("reset err", 16'(err0), 16'd0);
        rst0_n = 1'b1; rst3_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            req0(tbl[i], $sformatf("vec%0d", i));
        end

        // Back-to-back reads with req_valid held high: accepts every other cycle.
        b2b_addr[0] = 16'hC000; b2b_data[0] = 8'hA5;
        b2b_addr[1] = 16'hFF80; b2b_data[1] = 8'h11;
        b2b_addr[2] = 16'hFFFE; b2b_data[2] = 8'h22;
        b2b_addr[3] = 16'hDFFF; b2b_data[3] = 8'h3C;
        @(negedge clk);
        we0 = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) @(negedge clk);
            check($sformatf("b2b c%0d ready", c), 16'(rdy0), 16'((c % 2) == 0));
            check($sformatf("b2b c%0d rsp_valid", c), 16'(rv0), 16'((c % 2) == 1));
            if (c % 2 == 1) begin
                check($sformatf("b2b c%0d rdata", c), 16'(rd0), 16'(b2b_data[c/2]));
                a0 = 16'h8000;
            end else if (c > 0) begin
                check($sformatf("b2b c%0d rdata held", c), 16'(rd0), 16'(b2b_data[c/2-1]));
            end
            if (c % 2 == 0 && c < 8) begin
                v0 = 1'b1; a0 = b2b_addr[c/2];
            end
            if (c == 8) v0 = 1'b0;
        end

        // Three wait states: prime storage, then a hand-timed write with noisy inputs.
        req3('{1'b1, 16'hC021, 8'h00, 8'hFF, 1'b0}, "w3 prime c021");
        req3('{1'b1, 16'hFF81, 8'h00, 8'hFF, 1'b0}, "w3 prime ff81");
        @(negedge clk);
        check("w3 accept ready", 16'(rdy3), 16'd1);
        v3 = 1'b1; we3 = 1'b1; a3 = 16'hC020; wd3 = 8'h5A;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("w3 k%0d rsp_valid", k), 16'(rv3), 16'(k == 4));
            check($sformatf("w3 k%0d ready", k), 16'(rdy3), 16'(k == 5));
            if (k < 4) begin
                a3 = (k % 2 == 1) ? 16'hC021 : 16'hFF81;
                wd3 = 8'($urandom_range(1, 255));
            end
            if (k == 4) begin
                check("w3 err", 16'(err3), 16'd0);
                v3 = 1'b0;
            end
        end
        req3('{1'b0, 16'hC020, 8'h00, 8'h5A, 1'b0}, "w3 read c020");
        req3('{1'b0, 16'hC021, 8'h00, 8'h00, 1'b0}, "w3 read c021");
        req3('{1'b0, 16'hFF81, 8'h00, 8'h00, 1'b0}, "w3 read ff81");

        // Reset one cycle after accepting a write aborts it.
        req3('{1'b1, 16'hC010, 8'h3C, 8'h00, 1'b0}, "abort prime c010");
        req3('{1'b1, 16'hFFFF, 8'h1F, 8'h00, 1'b0}, "abort prime ie");
        @(negedge clk);
        v3 = 1'b1; we3 = 1'b1; a3 = 16'hC010; wd3 = 8'h77;
        @(negedge clk);
        v3 = 1'b0;
        rst3_n = 1'b0;
        #1;
        check("abort ready", 16'(rdy3), 16'd1);
        check("abort rsp_valid", 16'(rv3), 16'd0);
        check("abort rdata", 16'(rd3), 16'h00FF);
        @(negedge clk);
        rst3_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("abort quiet k%0d", k), 16'(rv3), 16'd0);
        end
        req3('{1'b0, 16'hC010, 8'h00, 8'h3C, 1'b0}, "abort read c010");
        req3('{1'b0, 16'hFFFF, 8'h00, 8'h00, 1'b0}, "abort read ie");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
